fp_root_seq: RTL and testbench

//  Sequential IEEE-754-style square root. Exponent and mantissa widths are parametrised; BITS_PER_CYCLE root bits are resolved per clock.

---
 rtl/fp_root_seq.sv | 209 ++++++++++++++++++++
 tb/tb_fp_root_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_root_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_root_seq
//  Description : Sequential IEEE-754-style square root. Restoring digit
//                recurrence producing BITS_PER_CYCLE root bits per clock,
//                round-to-nearest-even, full special-case handling, behind a
//                start/busy/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_root_seq #(
    parameter  int EXP_W          = 8,
    parameter  int MAN_W          = 23,
    parameter  int BITS_PER_CYCLE = 1,
    localparam int c_R            = MAN_W + 2,
    localparam int c_CYCLES       = (c_R + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE,
    localparam int c_CNT_W        = $clog2(c_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   d,
    output logic [EXP_W+MAN_W:0]   q,
    output logic                   busy,
    output logic                   ready,
    output logic                   invalid,
    output logic [c_CNT_W-1:0]     count
);

    localparam int c_W    = 1 + EXP_W + MAN_W;
    localparam int c_BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CALC  = 2'd1;
    localparam logic [1:0] c_ROUND = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // registered state
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_W-1:0]       r_q;
    logic                 r_invalid;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*c_R-1:0]     r_rad;
    logic [c_R+1:0]       r_rem;
    logic [c_R-1:0]       r_root;
    logic [EXP_W-1:0]     r_exp;

    // operand decode
    logic                 w_sign;
    logic [EXP_W-1:0]     w_e;
    logic [MAN_W-1:0]     w_f;
    logic                 w_special;
    logic [c_W-1:0]       w_special_q;
    logic                 w_special_inv;
    logic [EXP_W:0]       w_exp_sum;
    logic [2*c_R-1:0]     w_rad_init;
    logic                 w_accept;
    logic                 w_last_step;

    // recurrence / rounding
    logic [c_R+1:0]       w_rem_next;
    logic [c_R-1:0]       w_root_next;
    logic [2*c_R-1:0]     w_rad_next;
    logic [c_R+3:0]       w_shift;
    logic [c_R+3:0]       w_trial;
    logic                 w_inc;
    logic [MAN_W+1:0]     w_mant;
    logic [c_W-1:0]       w_round_q;

    assign w_sign = d[c_W-1];
    assign w_e    = d[c_W-2:MAN_W];
    assign w_f    = d[MAN_W-1:0];

    assign w_accept    = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last_step = (r_count == c_CNT_W'(c_CYCLES));

    // Operand classification: specials resolve immediately, normals go to CALC.
    always_comb begin
        w_special     = 1'b1;
        w_special_q   = c_QNAN;
        w_special_inv = 1'b0;
        if ((w_e == {EXP_W{1'b1}}) && (w_f != '0)) begin
            w_special_inv = ~w_f[MAN_W-1];
        end else if ((w_e == '0) && (w_f == '0)) begin
            w_special_q = d;
        end else if (w_e == '0) begin
            w_special_q = {w_sign, {(c_W-1){1'b0}}};
        end else if (w_sign) begin
            w_special_inv = 1'b1;
        end else if (w_e == {EXP_W{1'b1}}) begin
            w_special_q = d;
        end else begin
            w_special = 1'b0;
        end
    end

    // floor((e-BIAS)/2)+BIAS == floor((e+BIAS)/2); the LSB of e+BIAS gives the parity of e-BIAS.
    assign w_exp_sum  = {1'b0, w_e} + (EXP_W+1)'(c_BIAS);
    assign w_rad_init = w_exp_sum[0] ? {1'b1, w_f, {(MAN_W+3){1'b0}}}
                                     : {1'b0, 1'b1, w_f, {(MAN_W+2){1'b0}}};

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        ready        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_next = w_special ? c_DONE : c_CALC;
            end
            c_CALC: begin
                busy = 1'b1;
                if (w_last_step) w_state_next = c_ROUND;
            end
            c_ROUND: begin
                busy         = 1'b1;
                w_state_next = c_DONE;
            end
            default: begin
                ready        = 1'b1;
                w_state_next = w_accept ? (w_special ? c_DONE : c_CALC) : c_IDLE;
            end
        endcase
    end

    // BITS_PER_CYCLE restoring steps; the final step only resolves the bits still left.
    always_comb begin
        w_rem_next  = r_rem;
        w_root_next = r_root;
        w_rad_next  = r_rad;
        w_shift     = '0;
        w_trial     = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if ((int'(r_count) - 1) * BITS_PER_CYCLE + j < c_R) begin
                w_shift = {w_rem_next, w_rad_next[2*c_R-1 -: 2]};
                w_trial = {2'b00, w_root_next, 2'b01};
                if (w_shift >= w_trial) begin
                    w_shift     = w_shift - w_trial;
                    w_root_next = {w_root_next[c_R-2:0], 1'b1};
                end else begin
                    w_root_next = {w_root_next[c_R-2:0], 1'b0};
                end
                w_rem_next = w_shift[c_R+1:0];
                w_rad_next = {w_rad_next[2*c_R-3:0], 2'b00};
            end
        end
    end

    // Round to nearest even on the guard bit; a mantissa carry renormalises.
    always_comb begin
        w_inc  = r_root[0] & ((r_rem != '0) | r_root[1]);
        w_mant = {1'b0, r_root[c_R-1:1]} + (MAN_W+2)'(w_inc);
        if (w_mant[MAN_W+1]) begin
            w_round_q = {1'b0, r_exp + EXP_W'(1), w_mant[MAN_W:1]};
        end else begin
            w_round_q = {1'b0, r_exp, w_mant[MAN_W-1:0]};
        end
    end

    // Datapath registers: operand capture, recurrence state, result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q       <= '0;
            r_invalid <= 1'b0;
            r_count   <= '0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_exp     <= '0;
        end else if (w_accept) begin
            r_rad  <= w_rad_init;
            r_rem  <= '0;
            r_root <= '0;
            r_exp  <= w_exp_sum[EXP_W:1];
            if (w_special) begin
                r_q       <= w_special_q;
                r_invalid <= w_special_inv;
                r_count   <= '0;
            end else begin
                r_count   <= c_CNT_W'(1);
            end
        end else if (r_state == c_CALC) begin
            r_rad   <= w_rad_next;
            r_rem   <= w_rem_next;
            r_root  <= w_root_next;
            r_count <= w_last_step ? '0 : r_count + c_CNT_W'(1);
        end else if (r_state == c_ROUND) begin
            r_q       <= w_round_q;
            r_invalid <= 1'b0;
        end
    end

    assign q       = r_q;
    assign invalid = r_invalid;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_root_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_root_seq
//  Description : Scoreboard bench for fp_root_seq (1 and 4 bits per cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_root_seq;

    localparam int c_CYC1 = 25;
    localparam int c_CYC4 = 7;

    typedef struct {
        logic [31:0] q;
        logic        inv;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [31:0] d1 = '0, d4 = '0;
    logic [31:0] q1, q4;
    logic        busy1, busy4, ready1, ready4, inv1, inv4;
    logic [4:0]  count1;
    logic [2:0]  count4;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        exp1[$];
    exp_t        exp4[$];

    fp_root_seq #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(1)) u_dut1 (
        .clock(clk), .reset(rst), .start(start1), .d(d1), .q(q1),
        .busy(busy1), .ready(ready1), .invalid(inv1), .count(count1));

    fp_root_seq #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(4)) u_dut4 (
        .clock(clk), .reset(rst), .start(start4), .d(d4), .q(q4),
        .busy(busy4), .ready(ready4), .invalid(inv4), .count(count4));

    always #5 clk = ~clk;

    // cycle counter used to time-stamp expected ready cycles
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: classify by IEEE rules, otherwise sqrt in double and round once to single (RNE).
    function automatic void ref_model(input logic [31:0] x, output logic [31:0] rq,
                                      output logic ri, output bit sp);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [63:0] db;
        logic [63:0] b;
        logic [23:0] fr;
        real         r;
        int          es;
        logic        inc;
        s = x[31]; e = x[30:23]; f = x[22:0];
        sp = 1'b1; ri = 1'b0; rq = 32'h7FC00000;
        if (e == 8'hFF && f != '0)      ri = ~f[22];
        else if (e == '0 && f == '0)    rq = x;
        else if (e == '0)               rq = {s, 31'b0};
        else if (s)                     ri = 1'b1;
        else if (e == 8'hFF)            rq = x;
        else begin
            sp = 1'b0;
            es = int'(e) - 127 + 1023;
            db = {1'b0, 11'(es), f, 29'b0};
            r  = $sqrt($bitstoreal(db));
            b  = $realtobits(r);
            es = int'(b[62:52]) - 1023 + 127;
            inc = b[28] & ((|b[27:0]) | b[29]);
            fr = {1'b0, b[51:29]} + {23'b0, inc};
            if (fr[23]) es++;
            rq = {1'b0, 8'(es), fr[22:0]};
        end
    endfunction

    // Monitors: pop and compare whenever a DUT presents ready.
    always @(negedge clk) begin
        exp_t e;
        if (ready1) begin
            if (exp1.size() == 0) begin
                n_checks++;
                $display("FAIL ready1_unexpected: got ready=1 q=%h expected no result", q1);
            end else begin
                e = exp1.pop_front();
                chk("dut1_q", 64'(q1), 64'(e.q));
                chk("dut1_invalid", 64'(inv1), 64'(e.inv));
                chk("dut1_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (ready4) begin
            if (exp4.size() == 0) begin
                n_checks++;
                $display("FAIL ready4_unexpected: got ready=1 q=%h expected no result", q4);
            end else begin
                e = exp4.pop_front();
                chk("dut4_q", 64'(q4), 64'(e.q));
                chk("dut4_invalid", 64'(inv4), 64'(e.inv));
                chk("dut4_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue1(input logic [31:0] x, input logic [31:0] eq, input logic ei, input bit sp);
        exp1.push_back('{eq, ei, cyc + (sp ? 1 : c_CYC1 + 2)});
        d1 = x; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic issue4(input logic [31:0] x, input logic [31:0] eq, input logic ei, input bit sp);
        exp4.push_back('{eq, ei, cyc + (sp ? 1 : c_CYC4 + 2)});
        d4 = x; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (!ready1 && n < 100) begin @(posedge clk); #1; n++; end
        if (!ready1) begin n_checks++; $display("FAIL ready1_timeout: got no ready expected ready within 100 cycles"); end
    endtask

    task automatic wait_ready4();
        int n = 0;
        while (!ready4 && n < 100) begin @(posedge clk); #1; n++; end
        if (!ready4) begin n_checks++; $display("FAIL ready4_timeout: got no ready expected ready within 100 cycles"); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dir_x [10] = '{32'h40800000, 32'h40000000, 32'h41100000, 32'h3F800000,
                                    32'hC0000000, 32'h80000000, 32'h7F800000, 32'hFFFE0001,
                                    32'h7F800001, 32'h00000001};
        logic [31:0] dir_q [10] = '{32'h40000000, 32'h3FB504F3, 32'h40400000, 32'h3F800000,
                                    32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                                    32'h7FC00000, 32'h00000000};
        logic        dir_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit          dir_s [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] x, rq;
        logic        ri;
        bit          sp;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", 64'(q1), 64'(0));
        chk("reset_busy", 64'(busy1), 64'(0));
        chk("reset_ready", 64'(ready1), 64'(0));
        chk("reset_invalid", 64'(inv1), 64'(0));
        chk("reset_count", 64'(count1), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // directed values and specials
        for (int i = 0; i < 10; i++) begin
            issue1(dir_x[i], dir_q[i], dir_i[i], dir_s[i]);
            wait_ready1();
            @(posedge clk); #1;
            chk("ready_one_cycle", 64'(ready1), 64'(0));
        end

        // start during CALC is ignored
        issue1(32'h40800000, 32'h40000000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        d1 = 32'h41100000; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; d1 = 32'h3F800000;
        wait_ready1();

        // back-to-back start in the DONE cycle
        issue1(32'h41100000, 32'h40400000, 1'b0, 1'b0);
        chk("b2b_busy", 64'(busy1), 64'(1));
        wait_ready1();
        @(posedge clk); #1;

        // asynchronous reset ten cycles into CALC
        d1 = 32'h40000000; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy1), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("async_busy", 64'(busy1), 64'(0));
        chk("async_ready", 64'(ready1), 64'(0));
        chk("async_q", 64'(q1), 64'(0));
        chk("async_count", 64'(count1), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue1(32'h40000000, 32'h3FB504F3, 1'b0, 1'b0);
        wait_ready1();
        @(posedge clk); #1;

        // four bits per cycle: latency and count sequence
        issue4(32'h40000000, 32'h3FB504F3, 1'b0, 1'b0);
        for (int i = 1; i <= c_CYC4; i++) begin
            chk("count4_step", 64'(count4), 64'(i));
            @(posedge clk); #1;
        end
        chk("count4_cleared", 64'(count4), 64'(0));
        chk("busy4_round", 64'(busy4), 64'(1));
        wait_ready4();
        @(posedge clk); #1;

        // random normal positive operands
        n = 800;
        for (int i = 0; i < n; i++) begin
            x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            ref_model(x, rq, ri, sp);
            issue1(x, rq, ri, sp);
            wait_ready1();
            @(posedge clk); #1;
        end
        for (int i = 0; i < 1500; i++) begin
            x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            ref_model(x, rq, ri, sp);
            issue4(x, rq, ri, sp);
            wait_ready4();
            @(posedge clk); #1;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("drain_q1", 64'(exp1.size()), 64'(0));
        chk("drain_q4", 64'(exp4.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
